// File: rtl/lpm_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lpm_arith_pkg
//  Description : Shared types, constants and helpers for the math blocks
//                (divide, recombine). Contents:
//                  - lpm_state_t FSM state type with IDLE/MUL/ADD/DONE codes
//                  - REP_UNSIGNED / REP_SIGNED operand representation codes
//                  - is_negative / magnitude helpers on C_MAXW-bit values
//  Revision    : 1.0  initial release
// ============================================================================
package lpm_arith_pkg;

    localparam int REP_UNSIGNED = 0;
    localparam int REP_SIGNED   = 1;

    // Helpers work on a fixed wide container; callers sign-extend into it
    // and slice the result back down to their own width.
    localparam int C_MAXW = 64;

    typedef logic [1:0] lpm_state_t;
    localparam lpm_state_t C_ST_IDLE = 2'd0;
    localparam lpm_state_t C_ST_MUL  = 2'd1;
    localparam lpm_state_t C_ST_ADD  = 2'd2;
    localparam lpm_state_t C_ST_DONE = 2'd3;

    // An operand is negative only in the signed representation with its MSB set.
    function automatic logic is_negative(input logic msb, input int rep);
        return (rep == REP_SIGNED) && msb;
    endfunction

    // Absolute value of a sign-extended operand. The most-negative value
    // of a w-bit operand yields 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [C_MAXW-1:0] magnitude(input logic [C_MAXW-1:0] x_ext,
                                                    input logic             neg);
        return neg ? ((~x_ext) + 64'd1) : x_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpm_div_recombine_if.sv
`default_nettype none
// ============================================================================
//  Interface   : lpm_div_recombine_if
//  Description : Operand/result handshake bundle for lpm_div_recombine.
//                master : operand source and result sink (drives in_valid,
//                         quotient, denom, remain, out_ready)
//                slave  : the recombine block
//                Optional (DIV_RECOMBINE_CHECK_EN): numer_exp in, mismatch out.
//  Revision    : 1.0  initial release
// ============================================================================
interface lpm_div_recombine_if #(
    parameter int lpm_widthn = 16,
    parameter int lpm_widthd = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [lpm_widthn-1:0] quotient;
    logic [lpm_widthd-1:0] denom;
    logic [lpm_widthd-1:0] remain;
    logic                  out_valid;
    logic                  out_ready;
    logic [lpm_widthn-1:0] numer;
    logic                  overflow;
`ifdef DIV_RECOMBINE_CHECK_EN
    logic [lpm_widthn-1:0] numer_exp;
    logic                  mismatch;

    modport master (
        output in_valid, quotient, denom, remain, out_ready, numer_exp,
        input  in_ready, out_valid, numer, overflow, mismatch
    );
    modport slave (
        input  in_valid, quotient, denom, remain, out_ready, numer_exp,
        output in_ready, out_valid, numer, overflow, mismatch
    );
`else
    modport master (
        output in_valid, quotient, denom, remain, out_ready,
        input  in_ready, out_valid, numer, overflow
    );
    modport slave (
        input  in_valid, quotient, denom, remain, out_ready,
        output in_ready, out_valid, numer, overflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/lpm_shift_add_core.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_shift_add_core
//  Description : Unsigned iterative multiplier, one multiplier bit per step.
//                acc accumulates mcand<<i for every set bit i of mplier.
//  Ports       : clock, sclr_n (sync, active-low)
//                load   - clear acc/counter and capture operands
//                step   - perform one shift-add iteration
//                mcand  - multiplicand magnitude (lpm_widthd)
//                mplier - multiplier magnitude (lpm_widthn)
//                acc    - running product (lpm_widthn+lpm_widthd+1)
//                last   - current step is the final iteration
//  Revision    : 1.0  initial release
// ============================================================================
module lpm_shift_add_core #(
    parameter int lpm_widthn = 16,
    parameter int lpm_widthd = 8
) (
    input  wire logic                                 clock,
    input  wire logic                                 sclr_n,
    input  wire logic                                 load,
    input  wire logic                                 step,
    input  wire logic [lpm_widthd-1:0]                mcand,
    input  wire logic [lpm_widthn-1:0]                mplier,
    output logic      [lpm_widthn+lpm_widthd:0]       acc,
    output logic                                      last
);
    localparam int c_acc_w = lpm_widthn + lpm_widthd + 1;
    localparam int c_cnt_w = $clog2(lpm_widthn + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(lpm_widthn - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // The multiplicand is pre-shifted and the multiplier consumed LSB-first,
    // so no variable shifter is needed.
    logic [c_acc_w-1:0]    r_acc;
    logic [c_acc_w-1:0]    r_mcand;
    logic [lpm_widthn-1:0] r_mplier;
    logic [c_cnt_w-1:0]    r_cnt;

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_acc    <= '0;
            r_mcand  <= {{(c_acc_w-lpm_widthd){1'b0}}, mcand};
            r_mplier <= mplier;
            r_cnt    <= '0;
        end else if (step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_one;
        end
    end

    assign acc  = r_acc;
    assign last = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/lpm_div_recombine.sv
`default_nettype none
// ============================================================================
//  Module      : lpm_div_recombine
//  Description : Rebuilds numer = quotient*denom + remain (inverse of the
//                divider). Iterative shift-add, lpm_widthn MUL cycles, one
//                ADD cycle, then result held until out_ready.
//  Ports       : clock  - rising-edge clock
//                sclr_n - synchronous reset, active-low (beats clken)
//                clken  - clock enable, low freezes all state
//                bus    - lpm_div_recombine_if.slave (operands/result)
//  Options     : DIV_RECOMBINE_CHECK_EN adds numer_exp/mismatch compare.
//  Revision    : 1.0  initial release
// ============================================================================
module lpm_div_recombine
    import lpm_arith_pkg::*;
#(
    parameter int lpm_widthn = 16,
    parameter int lpm_widthd = 8,
    parameter int lpm_signed = 0
) (
    input  wire logic          clock,
    input  wire logic          sclr_n,
    input  wire logic          clken,
    lpm_div_recombine_if.slave bus
);
    localparam int c_acc_w = lpm_widthn + lpm_widthd + 1;
    localparam logic [c_acc_w-1:0] c_acc_one = {{(c_acc_w-1){1'b0}}, 1'b1};

    lpm_state_t r_state;
    lpm_state_t w_state_next;
    logic       w_in_ready;
    logic       w_out_valid;

    // ---------------- operand signing ----------------
    logic                  w_q_neg;
    logic                  w_d_neg;
    logic [C_MAXW-1:0]     w_q_mag_full;
    logic [C_MAXW-1:0]     w_d_mag_full;
    logic [lpm_widthn-1:0] w_q_mag;
    logic [lpm_widthd-1:0] w_d_mag;

    always_comb begin
        w_q_neg      = is_negative(bus.quotient[lpm_widthn-1], lpm_signed);
        w_d_neg      = is_negative(bus.denom[lpm_widthd-1], lpm_signed);
        w_q_mag_full = magnitude({{(C_MAXW-lpm_widthn){w_q_neg}}, bus.quotient}, w_q_neg);
        w_d_mag_full = magnitude({{(C_MAXW-lpm_widthd){w_d_neg}}, bus.denom}, w_d_neg);
        w_q_mag      = w_q_mag_full[lpm_widthn-1:0];
        w_d_mag      = w_d_mag_full[lpm_widthd-1:0];
    end

    // Upper container bits are always zero after slicing.
    logic w_unused_mag;
    assign w_unused_mag = ^{w_q_mag_full[C_MAXW-1:lpm_widthn],
                            w_d_mag_full[C_MAXW-1:lpm_widthd]};

    logic w_accept;
    logic w_step;
    assign w_accept = clken && (r_state == C_ST_IDLE) && bus.in_valid;
    assign w_step   = clken && (r_state == C_ST_MUL);

    logic [c_acc_w-1:0] w_acc;
    logic               w_last;

    lpm_shift_add_core #(
        .lpm_widthn (lpm_widthn),
        .lpm_widthd (lpm_widthd)
    ) u_core (
        .clock  (clock),
        .sclr_n (sclr_n),
        .load   (w_accept),
        .step   (w_step),
        .mcand  (w_d_mag),
        .mplier (w_q_mag),
        .acc    (w_acc),
        .last   (w_last)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_state <= C_ST_IDLE;
        end else if (clken) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: if (bus.in_valid)  w_state_next = C_ST_MUL;
            C_ST_MUL:  if (w_last)        w_state_next = C_ST_ADD;
            C_ST_ADD:                     w_state_next = C_ST_DONE;
            C_ST_DONE: if (bus.out_ready) w_state_next = C_ST_IDLE;
            default:                      w_state_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == C_ST_IDLE);
        w_out_valid = (r_state == C_ST_DONE);
    end

    // ---------------- sign, remain add, overflow ----------------
    logic                  r_neg;
    logic [lpm_widthd-1:0] r_remain;
    logic [lpm_widthn-1:0] r_numer;
    logic                  r_overflow;
    logic                  w_rem_sx;
    logic [c_acc_w-1:0]    w_prod;
    logic [c_acc_w-1:0]    w_exact;
    logic                  w_ovf;

    // The accumulator is wide enough that the signed/unsigned exact sum never
    // wraps, so overflow is just "upper bits are not a plain extension".
    always_comb begin
        w_rem_sx = (lpm_signed == REP_SIGNED) && r_remain[lpm_widthd-1];
        w_prod   = r_neg ? ((~w_acc) + c_acc_one) : w_acc;
        w_exact  = w_prod + {{(c_acc_w-lpm_widthd){w_rem_sx}}, r_remain};
        if (lpm_signed == REP_SIGNED) begin
            w_ovf = !((&w_exact[c_acc_w-1:lpm_widthn-1]) || !(|w_exact[c_acc_w-1:lpm_widthn-1]));
        end else begin
            w_ovf = |w_exact[c_acc_w-1:lpm_widthn];
        end
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_neg      <= 1'b0;
            r_remain   <= '0;
            r_numer    <= '0;
            r_overflow <= 1'b0;
        end else if (clken) begin
            if (w_accept) begin
                r_neg    <= w_q_neg ^ w_d_neg;
                r_remain <= bus.remain;
            end
            if (r_state == C_ST_ADD) begin
                r_numer    <= w_exact[lpm_widthn-1:0];
                r_overflow <= w_ovf;
            end
        end
    end

`ifdef DIV_RECOMBINE_CHECK_EN
    logic [lpm_widthn-1:0] r_numer_exp;
    logic                  r_mismatch;

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_numer_exp <= '0;
            r_mismatch  <= 1'b0;
        end else if (clken) begin
            if (w_accept) begin
                r_numer_exp <= bus.numer_exp;
            end
            if (r_state == C_ST_ADD) begin
                r_mismatch <= (w_exact[lpm_widthn-1:0] != r_numer_exp) || w_ovf;
            end
        end
    end

    assign bus.mismatch = r_mismatch;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.numer     = r_numer;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lpm_div_recombine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpm_div_recombine
//  Description : Self-checking bench for lpm_div_recombine. One unsigned and
//                one signed instance (widthn=16, widthd=8); table-driven jobs
//                with a result scoreboard plus reset/abort sequences.
//                Honours DIV_RECOMBINE_CHECK_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lpm_div_recombine;
    localparam int N = 16;
    localparam int D = 8;

    logic clk    = 1'b0;
    logic sclr_n = 1'b0;
    logic clken  = 1'b1;
    always #5 clk = ~clk;

    lpm_div_recombine_if #(.lpm_widthn(N), .lpm_widthd(D)) ifu ();
    lpm_div_recombine_if #(.lpm_widthn(N), .lpm_widthd(D)) ifs ();

    lpm_div_recombine #(.lpm_widthn(N), .lpm_widthd(D), .lpm_signed(0)) dut_u (
        .clock(clk), .sclr_n(sclr_n), .clken(clken), .bus(ifu.slave));
    lpm_div_recombine #(.lpm_widthn(N), .lpm_widthd(D), .lpm_signed(1)) dut_s (
        .clock(clk), .sclr_n(sclr_n), .clken(clken), .bus(ifs.slave));

    // Selected instance's outputs
    logic         sel = 1'b0;
    logic         o_in_ready, o_out_valid, o_ovf, o_mis;
    logic [N-1:0] o_numer;
    always_comb begin
        o_in_ready  = sel ? ifs.in_ready  : ifu.in_ready;
        o_out_valid = sel ? ifs.out_valid : ifu.out_valid;
        o_numer     = sel ? ifs.numer     : ifu.numer;
        o_ovf       = sel ? ifs.overflow  : ifu.overflow;
`ifdef DIV_RECOMBINE_CHECK_EN
        o_mis       = sel ? ifs.mismatch  : ifu.mismatch;
`else
        o_mis       = 1'b0;
`endif
    end

    typedef struct {
        bit           s;
        logic [N-1:0] q;
        logic [D-1:0] d;
        logic [D-1:0] r;
        logic [N-1:0] nexp;
        logic [N-1:0] numer;
        bit           ovf;
        int           stall;
        int           hold;
    } vec_t;

    typedef struct {
        logic [N-1:0] numer;
        bit           ovf;
        bit           mis;
    } exp_t;

    vec_t vt [14];
    exp_t sb [$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input bit s, input logic [N-1:0] q, input logic [D-1:0] d,
                           input logic [D-1:0] r, input logic [N-1:0] nexp);
        sel          = s;
        ifu.quotient = q;  ifs.quotient = q;
        ifu.denom    = d;  ifs.denom    = d;
        ifu.remain   = r;  ifs.remain   = r;
`ifdef DIV_RECOMBINE_CHECK_EN
        ifu.numer_exp = nexp;
        ifs.numer_exp = nexp;
`else
        if (nexp == '0) begin end
`endif
        ifu.in_valid = !s;
        ifs.in_valid = s;
    endtask

    task automatic run_job(input vec_t v);
        int   k;
        bit   seen;
        bit   bad;
        exp_t e;
        logic [N-1:0] snap;
        k = 0;
        while (!o_in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        set_ops(v.s, v.q, v.d, v.r, v.nexp);
        sb.push_back('{v.numer, v.ovf, (v.nexp != v.numer) || v.ovf});
        @(posedge clk); #1;                         // acceptance edge
        ifu.in_valid = 1'b0;
        ifs.in_valid = 1'b0;
        chk("in_ready_busy", 32'(o_in_ready), 32'd0);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            clken = (k < v.stall) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            k++;
            seen = o_out_valid;
        end
        clken = 1'b1;
        chk("latency", 32'(k), 32'(N + 1 + v.stall));
        if (v.hold > 0) begin
            bad  = 1'b0;
            snap = o_numer;
            repeat (v.hold) begin
                @(posedge clk); #1;
                if (o_numer !== snap || o_out_valid !== 1'b1 || o_in_ready !== 1'b0) bad = 1'b1;
            end
            chk("hold_stable", 32'(bad), 32'd0);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("numer", 32'(o_numer), 32'(e.numer));
            chk("overflow", 32'(o_ovf), 32'(e.ovf));
`ifdef DIV_RECOMBINE_CHECK_EN
            chk("mismatch", 32'(o_mis), 32'(e.mis));
`endif
        end
        ifu.out_ready = 1'b1;
        ifs.out_ready = 1'b1;
        @(posedge clk); #1;
        ifu.out_ready = 1'b0;
        ifs.out_ready = 1'b0;
        chk("release_valid", 32'(o_out_valid), 32'd0);
        chk("release_ready", 32'(o_in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //           s  q          d      r      nexp       numer      ovf stall hold
        vt[0]  = '{0, 16'd100,   8'd7,  8'd3,  16'd703,   16'd703,   0,  0,  0};
        vt[1]  = '{0, 16'hFFFF,  8'hFF, 8'h00, 16'hFF01,  16'hFF01,  1,  0,  5};
        vt[2]  = '{0, 16'd1234,  8'd0,  8'd5,  16'd5,     16'd5,     0,  0,  0};
        vt[3]  = '{0, 16'h0000,  8'h55, 8'hAA, 16'h00AA,  16'h00AA,  0,  0,  0};
        vt[4]  = '{0, 16'h1000,  8'h10, 8'h00, 16'h0000,  16'h0000,  1,  0,  0};
        vt[5]  = '{0, 16'h00FF,  8'hFF, 8'hFF, 16'hFF00,  16'hFF00,  0,  3,  0};
        vt[6]  = '{0, 16'h0101,  8'hFF, 8'h01, 16'h0000,  16'h0000,  1,  0,  0};
        vt[7]  = '{1, 16'hFFF2,  8'd7,  8'hFE, 16'hFF9C,  16'hFF9C,  0,  0,  0};
        vt[8]  = '{1, 16'h8000,  8'h01, 8'h00, 16'h8000,  16'h8000,  0,  0,  0};
        vt[9]  = '{1, 16'h8000,  8'hFF, 8'h00, 16'h8000,  16'h8000,  1,  0,  0};
        vt[10] = '{1, 16'h4000,  8'h02, 8'hFF, 16'h7FFF,  16'h7FFF,  0,  0,  0};
        vt[11] = '{1, 16'h0000,  8'h80, 8'h80, 16'hFF80,  16'hFF80,  0,  0,  0};
        vt[12] = '{1, 16'h7FFF,  8'h80, 8'h00, 16'h0080,  16'h0080,  1,  0,  0};
        vt[13] = '{0, 16'd100,   8'd7,  8'd3,  16'd704,   16'd703,   0,  0,  0};

        ifu.in_valid = 1'b0;  ifs.in_valid = 1'b0;
        ifu.out_ready = 1'b0; ifs.out_ready = 1'b0;
        set_ops(1'b0, '0, '0, '0, '0);
        ifu.in_valid = 1'b0;

        // Reset state of both instances
        sclr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_in_ready",  32'(o_in_ready),  32'd1);
            chk("rst_out_valid", 32'(o_out_valid), 32'd0);
            chk("rst_numer",     32'(o_numer),     32'd0);
            chk("rst_overflow",  32'(o_ovf),       32'd0);
        end
        sclr_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_job(vt[i]);
        end

        // Reset during MUL iteration 5 aborts with no output
        set_ops(1'b0, 16'hFFFF, 8'hFF, 8'h00, 16'h0000);
        @(posedge clk); #1;                         // accepted, iteration 0
        ifu.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;                                         // iteration 5
        sclr_n = 1'b0;
        @(posedge clk); #1;
        sclr_n = 1'b1;
        chk("abort_out_valid", 32'(o_out_valid), 32'd0);
        chk("abort_in_ready",  32'(o_in_ready),  32'd1);
        chk("abort_numer",     32'(o_numer),     32'd0);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(o_out_valid), 32'd0);

        v = '{0, 16'd3, 8'd4, 8'd1, 16'd13, 16'd13, 0, 0, 0};
        run_job(v);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
